// File: rtl/nic_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nic_fifo
//  Description : Network interface controller. It sits between a processor's
//                load/store register path and a router port, and buffers each
//                direction in its own DEPTH-entry FIFO.
//
//                Ports use big-endian bit order: index 0 is the MSB and
//                index N-1 is the LSB. Bit 0 of a packet is the
//                virtual-channel (VC) bit.
//
//                Processor register map (addr):
//                  00 out-data  : a store pushes the outbound FIFO; a load
//                                 returns zero
//                  01 out-status: {0.., out_cnt, out_full}
//                  10 in-data   : a load returns the inbound head and pops it
//                  11 in-status : {0.., ovf, in_cnt, in_valid}; a load
//                                 clears the sticky ovf bit
//
//  Ports       : clk, reset (async, active-low)
//                addr, d_in, nicEn, nicWrEn, d_out   processor side
//                net_polarity, net_ro, net_so, net_do router outbound
//                net_si, net_ri, net_di               router inbound
//  Revision    : 1.0  initial release
// ============================================================================
module nic_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  net_polarity,
    input  logic                  net_ro,
    output logic                  net_so,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

    localparam logic [0:1] c_ADDR_OUT_DATA = 2'b00;
    localparam logic [0:1] c_ADDR_OUT_STAT = 2'b01;
    localparam logic [0:1] c_ADDR_IN_DATA  = 2'b10;
    localparam logic [0:1] c_ADDR_IN_STAT  = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:DATA_WIDTH-1] r_out_mem [DEPTH];
    logic [PTR_W-1:0]      r_out_rd;
    logic [PTR_W-1:0]      r_out_wr;
    logic [CNT_W-1:0]      r_out_cnt;

    logic [0:DATA_WIDTH-1] r_in_mem [DEPTH];
    logic [PTR_W-1:0]      r_in_rd;
    logic [PTR_W-1:0]      r_in_wr;
    logic [CNT_W-1:0]      r_in_cnt;

    logic                  r_ovf;

    // ------------------------------------------------------------------
    // Decode and FIFO status
    // ------------------------------------------------------------------
    logic                  w_store;
    logic                  w_load;
    logic                  w_out_full;
    logic                  w_out_nempty;
    logic                  w_in_valid;
    logic                  w_in_full;
    logic [0:DATA_WIDTH-1] w_out_head;
    logic [0:DATA_WIDTH-1] w_in_head;
    logic                  w_out_push;
    logic                  w_out_pop;
    logic                  w_in_push;
    logic                  w_in_pop;
    logic                  w_ovf_evt;
    logic                  w_stat_rd;
    logic [0:DATA_WIDTH-1] w_out_stat;
    logic [0:DATA_WIDTH-1] w_in_stat;
    logic [0:DATA_WIDTH-1] w_dout;

    assign w_store      = nicEn & nicWrEn;
    assign w_load       = nicEn & ~nicWrEn;

    assign w_out_full   = (r_out_cnt == c_CNT_FULL);
    assign w_out_nempty = (r_out_cnt != '0);
    assign w_in_valid   = (r_in_cnt != '0);
    assign w_in_full    = (r_in_cnt == c_CNT_FULL);

    assign w_out_head   = r_out_mem[r_out_rd];
    assign w_in_head    = r_in_mem[r_in_rd];

    // Every accept decision looks at the pre-edge state only, so a full
    // FIFO refuses a push even in a cycle where it also pops.
    assign w_out_push   = w_store & (addr == c_ADDR_OUT_DATA) & ~w_out_full;
    assign w_out_pop    = net_so;
    assign w_in_push    = net_si & ~w_in_full;
    assign w_in_pop     = w_load & (addr == c_ADDR_IN_DATA) & w_in_valid;
    assign w_ovf_evt    = net_si & w_in_full;
    assign w_stat_rd    = w_load & (addr == c_ADDR_IN_STAT);

    // The router takes a word only while its polarity is opposite to the
    // head's VC bit.
    assign net_so = w_out_nempty & net_ro & (net_polarity != w_out_head[0]);
    assign net_do = w_out_nempty ? w_out_head : '0;
    assign net_ri = ~w_in_full;

    // Status words. The flag sits in the LSB and the count in the bits just
    // above it; the in-status word also carries ovf above the count.
    assign w_out_stat = {{(DATA_WIDTH-CNT_W-1){1'b0}}, r_out_cnt, w_out_full};
    assign w_in_stat  = {{(DATA_WIDTH-CNT_W-2){1'b0}}, r_ovf, r_in_cnt, w_in_valid};

    always_comb begin
        w_dout = '0;
        if (w_load) begin
            case (addr)
                c_ADDR_OUT_STAT: w_dout = w_out_stat;
                c_ADDR_IN_STAT:  w_dout = w_in_stat;
                c_ADDR_IN_DATA:  w_dout = w_in_valid ? w_in_head : '0;
                default:         w_dout = '0;
            endcase
        end
    end

    assign d_out = w_dout;

    // ------------------------------------------------------------------
    // FIFO storage. Memory contents are not reset; the pointers and counts
    // alone decide what is valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wr] <= d_in;
        end
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= net_di;
        end
    end

    // ------------------------------------------------------------------
    // Outbound pointers and count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_rd  <= '0;
            r_out_wr  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wr <= r_out_wr + c_PTR_ONE;
            end
            if (w_out_pop) begin
                r_out_rd <= r_out_rd + c_PTR_ONE;
            end
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + c_CNT_ONE;
                2'b01:   r_out_cnt <= r_out_cnt - c_CNT_ONE;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Inbound pointers, count and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_rd  <= '0;
            r_in_wr  <= '0;
            r_in_cnt <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_in_push) begin
                r_in_wr <= r_in_wr + c_PTR_ONE;
            end
            if (w_in_pop) begin
                r_in_rd <= r_in_rd + c_PTR_ONE;
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + c_CNT_ONE;
                2'b01:   r_in_cnt <= r_in_cnt - c_CNT_ONE;
                default: r_in_cnt <= r_in_cnt;
            endcase
            // A new overflow outranks the clear-on-read of the in-status word.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nic_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nic_fifo
//  Description : Directed self-checking bench for nic_fifo (DATA_WIDTH=64,
//                DEPTH=4). Inputs change on the falling edge; outputs are
//                sampled shortly after that, well away from the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nic_fifo;

    localparam int DW = 64;

    logic          clk;
    logic          reset;
    logic [0:1]    addr;
    logic [0:DW-1] d_in;
    logic          nicEn;
    logic          nicWrEn;
    logic [0:DW-1] d_out;
    logic          net_polarity;
    logic          net_ro;
    logic          net_so;
    logic [0:DW-1] net_do;
    logic          net_si;
    logic          net_ri;
    logic [0:DW-1] net_di;

    int n_cmp;
    int n_err;

    nic_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .d_out        (d_out),
        .net_polarity (net_polarity),
        .net_ro       (net_ro),
        .net_so       (net_so),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic do_store(input logic [0:1] a, input logic [63:0] d);
        @(negedge clk);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        @(posedge clk);
        #1 nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic do_load(input logic [0:1] a, output logic [63:0] d);
        @(negedge clk);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        #1 d = d_out;
        @(posedge clk);
        #1 nicEn = 1'b0;
    endtask

    task automatic do_in_push(input logic [63:0] d);
        @(negedge clk);
        net_si = 1'b1; net_di = d;
        @(posedge clk);
        #1 net_si = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] v;
        reset = 1'b0;
        #2;
        n_cmp++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL reset_net_ri got %0b want 1", net_ri); end
        n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL reset_net_so got %0b want 0", net_so); end
        n_cmp++; if (d_out !== 64'h0) begin n_err++; $display("FAIL reset_d_out got %h want 0", d_out); end
        n_cmp++; if (net_do !== 64'h0) begin n_err++; $display("FAIL reset_net_do got %h want 0", net_do); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL idle_out_status got %h want 0", v); end
        do_load(2'b11, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL idle_in_status got %h want 0", v); end
        do_load(2'b00, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL idle_out_data_load got %h want 0", v); end
    endtask

    task automatic test_out_fill();
        logic [63:0] v;
        net_ro = 1'b0; net_polarity = 1'b1;
        for (int i = 1; i <= 4; i++) do_store(2'b00, 64'(i));
        // A store to a non-data address must be ignored.
        do_store(2'b10, 64'h77);
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h9) begin n_err++; $display("FAIL out_status_full got %h want 9", v); end
        do_store(2'b00, 64'h5);
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h9) begin n_err++; $display("FAIL out_status_after_drop got %h want 9", v); end
        @(negedge clk);
        #1;
        n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL out_so_blocked got %0b want 0", net_so); end
        n_cmp++; if (net_do !== 64'h1) begin n_err++; $display("FAIL out_head got %h want 1", net_do); end
        net_ro = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++; if (net_so !== 1'b1) begin n_err++; $display("FAIL drain_so[%0d] got %0b want 1", i, net_so); end
            n_cmp++; if (net_do !== 64'(i)) begin n_err++; $display("FAIL drain_do[%0d] got %h want %h", i, net_do, 64'(i)); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL drain_so_empty got %0b want 0", net_so); end
        n_cmp++; if (net_do !== 64'h0) begin n_err++; $display("FAIL drain_do_empty got %h want 0", net_do); end
        net_ro = 1'b0;
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL out_status_drained got %h want 0", v); end
    endtask

    task automatic test_polarity();
        logic [63:0] v;
        net_ro = 1'b0;
        do_store(2'b00, 64'h8000_0000_0000_0005);
        @(negedge clk);
        net_ro = 1'b1; net_polarity = 1'b1;
        #1;
        n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL pol_same got %0b want 0", net_so); end
        net_polarity = 1'b0;
        #1;
        n_cmp++; if (net_so !== 1'b1) begin n_err++; $display("FAIL pol_diff got %0b want 1", net_so); end
        n_cmp++; if (net_do !== 64'h8000_0000_0000_0005) begin n_err++; $display("FAIL pol_do got %h want 8000000000000005", net_do); end
        @(posedge clk);
        #1 net_ro = 1'b0; net_polarity = 1'b1;
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL pol_status got %h want 0", v); end
    endtask

    task automatic test_in_fill();
        logic [63:0] v;
        logic [63:0] w [5];
        w[0] = 64'hA; w[1] = 64'hB; w[2] = 64'hC; w[3] = 64'hD; w[4] = 64'hE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            net_si = 1'b1; net_di = w[i];
            #1;
            n_cmp++; if (net_ri !== (i < 4)) begin n_err++; $display("FAIL in_ri[%0d] got %0b want %0b", i, net_ri, (i < 4)); end
            @(posedge clk);
            #1 net_si = 1'b0;
        end
        do_load(2'b11, v);
        n_cmp++; if (v !== 64'h19) begin n_err++; $display("FAIL in_status_ovf got %h want 19", v); end
        do_load(2'b11, v);
        n_cmp++; if (v !== 64'h9) begin n_err++; $display("FAIL in_status_cleared got %h want 9", v); end
        for (int i = 0; i < 4; i++) begin
            do_load(2'b10, v);
            n_cmp++; if (v !== w[i]) begin n_err++; $display("FAIL in_pop[%0d] got %h want %h", i, v, w[i]); end
        end
        do_load(2'b10, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL in_pop_empty got %h want 0", v); end
        do_load(2'b11, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL in_status_empty got %h want 0", v); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        net_ro = 1'b0; net_polarity = 1'b1;
        do_store(2'b00, 64'h11);
        do_store(2'b00, 64'h12);
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h4) begin n_err++; $display("FAIL b2b_out_pre got %h want 4", v); end
        @(negedge clk);
        net_ro = 1'b1; nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b00; d_in = 64'h13;
        #1;
        n_cmp++; if (net_so !== 1'b1) begin n_err++; $display("FAIL b2b_out_so got %0b want 1", net_so); end
        @(posedge clk);
        #1 nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h4) begin n_err++; $display("FAIL b2b_out_post got %h want 4", v); end
        @(negedge clk);
        net_ro = 1'b1;
        #1;
        n_cmp++; if (net_do !== 64'h12) begin n_err++; $display("FAIL b2b_out_head0 got %h want 12", net_do); end
        @(negedge clk);
        #1;
        n_cmp++; if (net_do !== 64'h13) begin n_err++; $display("FAIL b2b_out_head1 got %h want 13", net_do); end
        @(negedge clk);
        #1;
        n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL b2b_out_empty got %0b want 0", net_so); end
        net_ro = 1'b0;

        for (int i = 0; i < 4; i++) do_in_push(64'h20 + 64'(i));
        @(negedge clk);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b10; net_si = 1'b1; net_di = 64'hFF;
        #1;
        n_cmp++; if (d_out !== 64'h20) begin n_err++; $display("FAIL b2b_in_head got %h want 20", d_out); end
        n_cmp++; if (net_ri !== 1'b0) begin n_err++; $display("FAIL b2b_in_ri got %0b want 0", net_ri); end
        @(posedge clk);
        #1 nicEn = 1'b0; net_si = 1'b0;
        do_load(2'b11, v);
        n_cmp++; if (v !== 64'h17) begin n_err++; $display("FAIL b2b_in_status got %h want 17", v); end
        for (int i = 1; i < 4; i++) begin
            do_load(2'b10, v);
            n_cmp++; if (v !== 64'h20 + 64'(i)) begin n_err++; $display("FAIL b2b_in_pop[%0d] got %h want %h", i, v, 64'h20 + 64'(i)); end
        end
        do_load(2'b11, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL b2b_in_final got %h want 0", v); end
    endtask

    task automatic test_async_reset();
        logic [63:0] v;
        net_ro = 1'b0; net_polarity = 1'b1;
        do_store(2'b00, 64'h31);
        do_store(2'b00, 64'h32);
        for (int i = 0; i < 4; i++) do_in_push(64'h40 + 64'(i));
        @(negedge clk);
        #1;
        n_cmp++; if (net_ri !== 1'b0) begin n_err++; $display("FAIL ares_pre_ri got %0b want 0", net_ri); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        net_ro = 1'b1;
        #1;
        n_cmp++; if (net_so !== 1'b0) begin n_err++; $display("FAIL ares_so got %0b want 0", net_so); end
        n_cmp++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL ares_ri got %0b want 1", net_ri); end
        n_cmp++; if (net_do !== 64'h0) begin n_err++; $display("FAIL ares_do got %h want 0", net_do); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; net_ro = 1'b0;
        do_load(2'b01, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL ares_out_status got %h want 0", v); end
        do_load(2'b11, v);
        n_cmp++; if (v !== 64'h0) begin n_err++; $display("FAIL ares_in_status got %h want 0", v); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_polarity = 1'b1; net_ro = 1'b0; net_si = 1'b0; net_di = '0;
        test_reset();
        test_out_fill();
        test_polarity();
        test_in_fill();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
